// File: rtl/rgb_conv3x3_stream_layer.sv
// Streaming 3x3 valid-mode convolution over NUM_CH channels, NUM_FILTERS filters in parallel.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   load_start_i             request a weight (re)load
//   w_valid_i/w_ready_o      signed weight word handshake, w_data_i
//   pix_valid_i/pix_ready_o  pixel handshake, pix_data_i (ch0 in LSBs)
//   conv_valid_o             1-cycle pulse qualifying conv_out_o/out_row_o/out_col_o
//   conv_out_o               signed results, filter0 in LSBs
//   frame_done_o             pulses with the last output of a frame
//   weights_ok_o             a complete weight set is loaded
module rgb_conv3x3_stream_layer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned NUM_FILTERS = 4,
    parameter int unsigned IMG_W       = 8,
    parameter int unsigned IMG_H       = 8,
    parameter int unsigned ACC_WIDTH   = 22,
    parameter int unsigned RELU_EN     = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_start_i,
    input  logic                              w_valid_i,
    output logic                              w_ready_o,
    input  logic [DATA_WIDTH-1:0]             w_data_i,
    input  logic                              pix_valid_i,
    output logic                              pix_ready_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      pix_data_i,
    output logic                              conv_valid_o,
    output logic [NUM_FILTERS*ACC_WIDTH-1:0]  conv_out_o,
    output logic [$clog2(IMG_H)-1:0]          out_row_o,
    output logic [$clog2(IMG_W)-1:0]          out_col_o,
    output logic                              frame_done_o,
    output logic                              weights_ok_o
);
    localparam int unsigned NW  = NUM_FILTERS * NUM_CH * 9;
    localparam int unsigned NWW = $clog2(NW);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam int unsigned CW  = $clog2(IMG_W);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                       state_q;
    logic                         w_ready_q, pix_ready_q, weights_ok_q;
    logic [NWW-1:0]               w_cnt_q;
    logic signed [DATA_WIDTH-1:0] w_q [NW];

    logic [RW-1:0]                row_q;
    logic [CW-1:0]                col_q;
    logic [DATA_WIDTH-1:0]        lb0_q [NUM_CH][IMG_W];  // row-1
    logic [DATA_WIDTH-1:0]        lb1_q [NUM_CH][IMG_W];  // row-2
    logic [DATA_WIDTH-1:0]        win_q [NUM_CH][3][3];   // [ch][r][c], r=0 top, c=0 left
    logic                         win_vld_q, win_last_q;
    logic [RW-1:0]                win_row_q;
    logic [CW-1:0]                win_col_q;

    logic signed [ACC_WIDTH-1:0]  psum_d [NUM_FILTERS][NUM_CH];
    logic signed [ACC_WIDTH-1:0]  psum_q [NUM_FILTERS][NUM_CH];
    logic                         s1_vld_q, s1_last_q;
    logic [RW-1:0]                s1_row_q;
    logic [CW-1:0]                s1_col_q;

    logic [NUM_FILTERS*ACC_WIDTH-1:0] conv_out_d, conv_out_q;
    logic                         conv_valid_q, frame_done_q;
    logic [RW-1:0]                out_row_q;
    logic [CW-1:0]                out_col_q;

    logic                         frame_idle, w_acc, pix_acc, last_pix;
    logic signed [ACC_WIDTH-1:0]  acc_v, px_v, wt_v, sum_v;

    assign frame_idle = (row_q == '0) && (col_q == '0) && !win_vld_q && !s1_vld_q;
    assign w_acc      = w_valid_i && w_ready_q;
    // A reload request at frame idle takes precedence over a pixel in the same cycle.
    assign pix_acc    = pix_valid_i && pix_ready_q && !(load_start_i && frame_idle);
    assign last_pix   = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            w_ready_q    <= 1'b0;
            pix_ready_q  <= 1'b0;
            weights_ok_q <= 1'b0;
            w_cnt_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (load_start_i) begin
                    state_q      <= StLoad;
                    w_ready_q    <= 1'b1;
                    weights_ok_q <= 1'b0;
                    w_cnt_q      <= '0;
                end
                StLoad: if (w_acc) begin
                    if (w_cnt_q == NWW'(NW - 1)) begin
                        state_q      <= StRun;
                        w_ready_q    <= 1'b0;
                        pix_ready_q  <= 1'b1;
                        weights_ok_q <= 1'b1;
                        w_cnt_q      <= '0;
                    end else begin
                        w_cnt_q <= w_cnt_q + NWW'(1);
                    end
                end
                StRun: if (load_start_i && frame_idle) begin
                    state_q      <= StLoad;
                    w_ready_q    <= 1'b1;
                    pix_ready_q  <= 1'b0;
                    weights_ok_q <= 1'b0;
                    w_cnt_q      <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NW; n++) w_q[n] <= '0;
        end else if (w_acc) begin
            w_q[w_cnt_q] <= w_data_i;
        end
    end

    // Line buffers, window shift and raster position; all frozen unless a pixel is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q      <= '0;
            col_q      <= '0;
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
            win_row_q  <= '0;
            win_col_q  <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int x = 0; x < IMG_W; x++) begin
                    lb0_q[ch][x] <= '0;
                    lb1_q[ch][x] <= '0;
                end
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) win_q[ch][r][c] <= '0;
                end
            end
        end else begin
            win_vld_q <= pix_acc && (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (pix_acc) begin
                win_row_q  <= row_q - RW'(2);
                win_col_q  <= col_q - CW'(2);
                win_last_q <= last_pix;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    for (int r = 0; r < 3; r++) begin
                        win_q[ch][r][0] <= win_q[ch][r][1];
                        win_q[ch][r][1] <= win_q[ch][r][2];
                    end
                    win_q[ch][0][2]     <= lb1_q[ch][col_q];
                    win_q[ch][1][2]     <= lb0_q[ch][col_q];
                    win_q[ch][2][2]     <= pix_data_i[ch*DATA_WIDTH +: DATA_WIDTH];
                    lb1_q[ch][col_q]    <= lb0_q[ch][col_q];
                    lb0_q[ch][col_q]    <= pix_data_i[ch*DATA_WIDTH +: DATA_WIDTH];
                end
                if (last_pix) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (col_q == CW'(IMG_W - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Per-filter, per-channel 9-tap sums; pixels are zero-extended, weights sign-extended.
    always_comb begin
        acc_v = '0;
        px_v  = '0;
        wt_v  = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_v = '0;
                for (int k = 0; k < 9; k++) begin
                    px_v  = ACC_WIDTH'(win_q[ch][k/3][k%3]);
                    wt_v  = ACC_WIDTH'(w_q[NWW'(f*9*NUM_CH + ch*9 + k)]);
                    acc_v = acc_v + px_v * wt_v;
                end
                psum_d[f][ch] = acc_v;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int ch = 0; ch < NUM_CH; ch++) psum_q[f][ch] <= '0;
            end
        end else begin
            s1_vld_q <= win_vld_q;
            if (win_vld_q) begin
                s1_last_q <= win_last_q;
                s1_row_q  <= win_row_q;
                s1_col_q  <= win_col_q;
                psum_q    <= psum_d;
            end
        end
    end

    always_comb begin
        conv_out_d = '0;
        sum_v      = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            sum_v = '0;
            for (int ch = 0; ch < NUM_CH; ch++) sum_v = sum_v + psum_q[f][ch];
            if ((RELU_EN != 0) && sum_v[ACC_WIDTH-1]) sum_v = '0;
            conv_out_d[f*ACC_WIDTH +: ACC_WIDTH] = sum_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            conv_out_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            conv_valid_q <= s1_vld_q;
            frame_done_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                conv_out_q <= conv_out_d;
                out_row_q  <= s1_row_q;
                out_col_q  <= s1_col_q;
            end
        end
    end

    assign w_ready_o    = w_ready_q;
    assign pix_ready_o  = pix_ready_q;
    assign weights_ok_o = weights_ok_q;
    assign conv_valid_o = conv_valid_q;
    assign conv_out_o   = conv_out_q;
    assign out_row_o    = out_row_q;
    assign out_col_o    = out_col_q;
    assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_rgb_conv3x3_stream_layer.sv
// Randomized bench for rgb_conv3x3_stream_layer: a plain 3x3 convolution model over stored
// frames/weights predicts every output, its position, frame_done and its arrival cycle.
module tb_rgb_conv3x3_stream_layer;
    localparam int DW = 8;
    localparam int NC = 3;
    localparam int NF = 4;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 22;
    localparam int NW = NF * NC * 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           load_start, w_valid, pix_valid;
    logic [DW-1:0]  w_data;
    logic [NC*DW-1:0] pix_data;
    logic           w_ready, pix_ready, conv_valid, frame_done, weights_ok;
    logic [NF*AW-1:0] conv_out;
    logic [2:0]     out_row, out_col;
    logic           w_ready_r, pix_ready_r, conv_valid_r, frame_done_r, weights_ok_r;
    logic [NF*AW-1:0] conv_out_r;
    logic [2:0]     out_row_r, out_col_r;

    always #5 clk = ~clk;

    rgb_conv3x3_stream_layer #(.RELU_EN(0)) u_dut (
        .clk(clk), .rst(rst), .load_start_i(load_start),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
        .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
        .conv_valid_o(conv_valid), .conv_out_o(conv_out), .out_row_o(out_row),
        .out_col_o(out_col), .frame_done_o(frame_done), .weights_ok_o(weights_ok)
    );

    rgb_conv3x3_stream_layer #(.RELU_EN(1)) u_dut_relu (
        .clk(clk), .rst(rst), .load_start_i(load_start),
        .w_valid_i(w_valid), .w_ready_o(w_ready_r), .w_data_i(w_data),
        .pix_valid_i(pix_valid), .pix_ready_o(pix_ready_r), .pix_data_i(pix_data),
        .conv_valid_o(conv_valid_r), .conv_out_o(conv_out_r), .out_row_o(out_row_r),
        .out_col_o(out_col_r), .frame_done_o(frame_done_r), .weights_ok_o(weights_ok_r)
    );

    typedef struct packed {
        longint            cyc;
        int                row;
        int                col;
        bit                fd;
        logic [NF*32-1:0]  v;
        logic [NF*32-1:0]  vr;
    } exp_t;

    int     pix_m [H][W][NC];
    int     w_m   [NF][NC][9];
    exp_t   exp_q [$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_out(int f, int r0, int c0, bit relu);
        int s = 0;
        for (int ch = 0; ch < NC; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += pix_m[r0+r][c0+c][ch] * w_m[f][ch][3*r+c];
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    // Output scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (conv_valid || conv_valid_r) begin
                check("relu_vld", conv_valid_r, conv_valid);
                if (exp_q.size() == 0) begin
                    check("unexpected_vld", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", cyc, mon_e.cyc);
                    check("out_row", out_row, mon_e.row);
                    check("out_col", out_col, mon_e.col);
                    check("frame_done", frame_done, mon_e.fd);
                    check("relu_row", out_row_r, mon_e.row);
                    for (int f = 0; f < NF; f++) begin
                        check("conv_out", longint'($signed(conv_out[f*AW +: AW])),
                              longint'($signed(mon_e.v[f*32 +: 32])));
                        check("relu_out", longint'($signed(conv_out_r[f*AW +: AW])),
                              longint'($signed(mon_e.vr[f*32 +: 32])));
                    end
                end
            end else if (frame_done) begin
                check("stray_frame_done", 1, 0);
            end
        end
    end

    task automatic check_reset_outs();
        check("rst_w_ready", w_ready, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_conv_valid", conv_valid, 0);
        check("rst_conv_out", longint'(|conv_out), 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_weights_ok", weights_ok, 0);
    endtask

    task automatic fill_w(input int mode, input int v);
        for (int f = 0; f < NF; f++)
            for (int ch = 0; ch < NC; ch++)
                for (int k = 0; k < 9; k++) begin
                    if (mode == 0)      w_m[f][ch][k] = v;
                    else if (mode == 1) w_m[f][ch][k] = (f == 0 && ch == 0 && k == 4) ? 1 : 0;
                    else                w_m[f][ch][k] = int'($urandom_range(255)) - 128;
                end
    endtask

    task automatic fill_pix(input int mode, input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int ch = 0; ch < NC; ch++) begin
                    if (mode == 0)                  pix_m[r][c][ch] = v;
                    else if (mode == 1 && ch == 0)  pix_m[r][c][ch] = 8*r + c;
                    else                            pix_m[r][c][ch] = int'($urandom_range(255));
                end
    endtask

    // Entered and left on a falling edge.
    task automatic load_weights(input bit issue_start);
        int to;
        if (issue_start) begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
        end
        check("load_w_ready", w_ready, 1);
        check("load_weights_ok", weights_ok, 0);
        for (int n = 0; n < NW; n++) begin
            while ($urandom_range(3) == 0) begin
                w_valid = 1'b0;
                @(negedge clk);
            end
            w_valid = 1'b1;
            w_data  = DW'(w_m[n/(9*NC)][(n/9)%NC][n%9]);
            to = 0;
            while (!w_ready && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (to >= 50) begin
                check("w_ready_timeout", 0, 1);
                w_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        w_valid = 1'b0;
        check("loaded_weights_ok", weights_ok, 1);
        check("loaded_pix_ready", pix_ready, 1);
        check("loaded_w_ready", w_ready, 0);
    endtask

    task automatic note_accept(input int r, input int c);
        exp_t e;
        if (r >= 2 && c >= 2) begin
            e.cyc = cyc + 3;
            e.row = r - 2;
            e.col = c - 2;
            e.fd  = (r == H-1 && c == W-1);
            for (int f = 0; f < NF; f++) begin
                e.v[f*32 +: 32]  = ref_out(f, r-2, c-2, 1'b0);
                e.vr[f*32 +: 32] = ref_out(f, r-2, c-2, 1'b1);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int idle_pct, input int ls_at, input int abort_at);
        int to;
        logic [NC*DW-1:0] pd;
        for (int p = 0; p < H*W; p++) begin
            while (int'($urandom_range(99)) < idle_pct) begin
                pix_valid = 1'b0;
                pix_data  = NC*DW'($urandom);
                @(negedge clk);
            end
            if (p == abort_at) begin
                pix_valid = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset_outs();
                exp_q.delete();
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                check("post_rst_weights_ok", weights_ok, 0);
                check("post_rst_pix_ready", pix_ready, 0);
                return;
            end
            for (int ch = 0; ch < NC; ch++) pd[ch*DW +: DW] = DW'(pix_m[p/W][p%W][ch]);
            pix_valid = 1'b1;
            pix_data  = pd;
            to = 0;
            while (!pix_ready && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (to >= 50) begin
                check("pix_ready_timeout", 0, 1);
                pix_valid = 1'b0;
                return;
            end
            note_accept(p/W, p%W);
            if (p == ls_at) load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        w_valid = 1'b0;
        w_data = '0;
        pix_valid = 1'b0;
        pix_data = '0;
        #1 check_reset_outs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All-ones weights and pixels: 27 everywhere.
        fill_w(0, 1);
        load_weights(1'b1);
        fill_pix(0, 1);
        send_frame(0, -1, -1);
        drain();

        // Single centre tap on filter0/ch0 with a ramp image.
        fill_w(1, 0);
        load_weights(1'b1);
        fill_pix(1, 0);
        send_frame(0, -1, -1);
        drain();

        // Most negative sum; the ReLU instance must clamp to 0.
        fill_w(0, -128);
        load_weights(1'b1);
        fill_pix(0, 255);
        send_frame(0, -1, -1);
        drain();

        // Stalled stream.
        fill_w(0, 1);
        load_weights(1'b1);
        fill_pix(0, 1);
        send_frame(50, -1, -1);
        drain();

        // Mid-frame reload request is ignored.
        send_frame(0, 20, -1);
        drain();
        check("midframe_load_ignored", w_ready, 0);

        // At frame idle, load_start wins over a simultaneous pixel.
        load_start = 1'b1;
        pix_valid  = 1'b1;
        pix_data   = '1;
        @(negedge clk);
        load_start = 1'b0;
        pix_valid  = 1'b0;
        check("idle_load_w_ready", w_ready, 1);
        check("idle_load_pix_ready", pix_ready, 0);
        fill_w(0, 2);
        load_weights(1'b0);
        send_frame(0, -1, -1);
        drain();

        // Random weights and pixels.
        for (int i = 0; i < 2; i++) begin
            fill_w(2, 0);
            load_weights(1'b1);
            fill_pix(2, 0);
            send_frame(30, -1, -1);
            drain();
        end

        // Reset mid-frame, then full reload.
        fill_w(0, 1);
        load_weights(1'b1);
        fill_pix(0, 1);
        send_frame(0, -1, 30);
        load_weights(1'b1);
        send_frame(0, -1, -1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
